// File: rtl/prog_readback.sv
// prog_readback: dumps the first len bytes of program RAM over UART.
// Data goes out as 8N1 frames in little-endian byte order, followed by one
// 8-bit additive checksum byte so the host can verify a download.
// It only runs while programming mode holds the core stalled. The top level
// muxes memAddr onto the program-RAM address port.
//
// Ports:
//   clk      system clock
//   rstB     asynchronous active-low reset
//   start    one-cycle dump request, honoured only when idle
//   len      number of data bytes to send, latched on an accepted start
//   memRdEn  program-RAM read strobe, one cycle per 32-bit word
//   memAddr  word-aligned byte address of the word being read
//   memData  RAM read data, valid the cycle after memRdEn
//   tx       UART serial output, idle high
//   busy     high from an accepted start through the checksum stop bit
//   done     one-cycle pulse after the checksum stop bit completes
module prog_readback #(
  parameter int  MEM_SIZE   = 32767,
  parameter int  BAUD_CYCLE = 868,
  localparam int ADDRW      = $clog2(MEM_SIZE)
) (
  input  logic             clk,
  input  logic             rstB,
  input  logic             start,
  input  logic [ADDRW:0]   len,
  output logic             memRdEn,
  output logic [ADDRW-1:0] memAddr,
  input  logic [31:0]      memData,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  // The baud counter counts down from BAUD_CYCLE-1 to 0, so one bit lasts
  // exactly BAUD_CYCLE clocks.
  localparam int              BW        = (BAUD_CYCLE > 1) ? $clog2(BAUD_CYCLE) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_CYCLE - 1);
  localparam logic [ADDRW:0]  REM_ONE   = (ADDRW + 1)'(1);
  localparam logic [ADDRW-1:0] IDX_ONE  = ADDRW'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_CHK,
    S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [ADDRW:0]   remaining_q, remaining_d;
  logic [ADDRW-1:0] byteidx_q, byteidx_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [31:0]      word_q, word_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       checksum_q, checksum_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic             chk_flag_q, chk_flag_d;

  logic             baud_tick;
  logic [ADDRW-1:0] byteidx_nxt;
  logic [ADDRW-1:0] fetch_addr;
  logic [7:0]       cur_byte;

  assign baud_tick   = (baud_q == '0);
  assign byteidx_nxt = byteidx_q + IDX_ONE;
  assign fetch_addr  = {byteidx_q[ADDRW-1:2], 2'b00};

  always_comb begin
    cur_byte = word_q[7:0];
    case (byteidx_q[1:0])
      2'd0: cur_byte = word_q[7:0];
      2'd1: cur_byte = word_q[15:8];
      2'd2: cur_byte = word_q[23:16];
      2'd3: cur_byte = word_q[31:24];
      default: cur_byte = word_q[7:0];
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? S_CHK : S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_CHK:   state_d = S_START;
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick && (bitcnt_q == 3'd7)) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (chk_flag_q) begin
            state_d = S_FIN;
          end else if (remaining_q == REM_ONE) begin
            state_d = S_CHK;
          end else if (byteidx_nxt[1:0] == 2'b00) begin
            // Crossing into a new word: read memory once for all its bytes.
            state_d = S_FETCH;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    tx      = 1'b1;
    busy    = 1'b1;
    done    = 1'b0;
    memRdEn = 1'b0;
    memAddr = addr_q;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_FETCH: begin
        memRdEn = 1'b1;
        memAddr = fetch_addr;
      end
      S_START: begin
        tx = 1'b0;
      end
      S_DATA: begin
        tx = shift_q[0];
      end
      S_FIN: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: begin
        tx = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  always_comb begin
    remaining_d = remaining_q;
    byteidx_d   = byteidx_q;
    addr_d      = addr_q;
    word_d      = word_q;
    shift_d     = shift_q;
    checksum_d  = checksum_q;
    baud_d      = baud_q;
    bitcnt_d    = bitcnt_q;
    chk_flag_d  = chk_flag_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = len;
          byteidx_d   = '0;
          checksum_d  = '0;
          chk_flag_d  = 1'b0;
        end
      end
      S_FETCH: begin
        // memAddr keeps showing this address after the strobe drops.
        addr_d = fetch_addr;
      end
      S_WAIT: begin
        word_d = memData;
      end
      S_LOAD: begin
        shift_d    = cur_byte;
        checksum_d = checksum_q + cur_byte;
        baud_d     = BAUD_LAST;
        bitcnt_d   = 3'd0;
      end
      S_CHK: begin
        shift_d    = checksum_q;
        chk_flag_d = 1'b1;
        baud_d     = BAUD_LAST;
        bitcnt_d   = 3'd0;
      end
      S_START: begin
        baud_d = baud_tick ? BAUD_LAST : baud_q - BW'(1);
      end
      S_DATA: begin
        baud_d = baud_tick ? BAUD_LAST : baud_q - BW'(1);
        if (baud_tick) begin
          shift_d  = {1'b0, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      S_STOP: begin
        baud_d = baud_tick ? BAUD_LAST : baud_q - BW'(1);
        if (baud_tick && !chk_flag_q) begin
          remaining_d = remaining_q - REM_ONE;
          byteidx_d   = byteidx_nxt;
        end
      end
      S_FIN: begin
        chk_flag_d = 1'b0;
      end
      default: begin
        chk_flag_d = chk_flag_q;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      remaining_q <= '0;
      byteidx_q   <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      shift_q     <= '0;
      checksum_q  <= '0;
      baud_q      <= '0;
      bitcnt_q    <= '0;
      chk_flag_q  <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      byteidx_q   <= byteidx_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      shift_q     <= shift_d;
      checksum_q  <= checksum_d;
      baud_q      <= baud_d;
      bitcnt_q    <= bitcnt_d;
      chk_flag_q  <= chk_flag_d;
    end
  end

endmodule

// File: tb/tb_prog_readback.sv
// Bench for prog_readback: random and directed dumps, decoded from tx by a
// UART receiver and compared against a byte-level memory model.
// Also covers restart-while-busy and asynchronous reset mid-frame.
module tb_prog_readback;
  localparam int MEM_SIZE = 64;
  localparam int BAUD     = 4;
  localparam int ADDRW    = $clog2(MEM_SIZE);
  localparam int ASPAN    = 1 << ADDRW;

  logic             clk = 1'b0;
  logic             rstB;
  logic             start;
  logic [ADDRW:0]   len;
  logic             memRdEn;
  logic [ADDRW-1:0] memAddr;
  logic [31:0]      memData;
  logic             tx;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  prog_readback #(.MEM_SIZE(MEM_SIZE), .BAUD_CYCLE(BAUD)) dut (
    .clk     (clk),
    .rstB    (rstB),
    .start   (start),
    .len     (len),
    .memRdEn (memRdEn),
    .memAddr (memAddr),
    .memData (memData),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  // Byte-addressed program memory model with one-cycle read latency.
  logic [7:0] mem_b [MEM_SIZE];

  always @(posedge clk) begin
    if (memRdEn) begin
      memData <= {mem_b[{memAddr[ADDRW-1:2], 2'd3}], mem_b[{memAddr[ADDRW-1:2], 2'd2}],
                  mem_b[{memAddr[ADDRW-1:2], 2'd1}], mem_b[{memAddr[ADDRW-1:2], 2'd0}]};
    end
  end

  // Observations collected by the monitor; the main block only reads them.
  logic [7:0] rx_q[$];
  int         rd_q[$];
  int         gap_q[$];
  int         done_cnt  = 0;
  int         frame_err = 0;

  int checks = 0;
  int errors = 0;

  // UART receiver plus strobe monitor, sampling on the falling edge.
  initial begin : monitor
    int         k;
    int         bitn;
    int         idle;
    bit         in_frame;
    logic [7:0] cur;
    k = 0; idle = 0; in_frame = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (rstB !== 1'b1) begin
        in_frame = 0;
        idle     = 0;
      end else begin
        if (memRdEn === 1'b1) rd_q.push_back(int'(memAddr));
        if (done === 1'b1) begin
          done_cnt++;
          if (busy !== 1'b0) frame_err++;
        end
        if (!in_frame) begin
          if (tx === 1'b0) begin
            in_frame = 1;
            k        = 0;
            gap_q.push_back(idle);
          end else begin
            idle++;
          end
        end
        if (in_frame) begin
          bitn = k / BAUD;
          if (bitn == 0) begin
            if (tx !== 1'b0) frame_err++;
          end else if (bitn <= 8) begin
            if ((k % BAUD) == 0) cur[bitn-1] = tx;
            else if (tx !== cur[bitn-1]) frame_err++;
          end else begin
            if (tx !== 1'b1) frame_err++;
          end
          k++;
          if (k == 10 * BAUD) begin
            rx_q.push_back(cur);
            in_frame = 0;
            idle     = 0;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the byte at dump position i is memory byte i (address wraps).
  function automatic logic [7:0] ref_byte(input int i);
    return mem_b[i % ASPAN];
  endfunction

  function automatic logic [7:0] ref_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(ref_byte(i));
    return 8'(s);
  endfunction

  function automatic logic [31:0] rx_at(input int idx);
    if (idx < rx_q.size()) return 32'(rx_q[idx]);
    return 32'hxxxx_xxxx;
  endfunction

  int b_rx, b_rd, b_gap, b_done, b_err;

  task automatic snapshot();
    b_rx   = rx_q.size();
    b_rd   = rd_q.size();
    b_gap  = gap_q.size();
    b_done = done_cnt;
    b_err  = frame_err;
  endtask

  task automatic kick(input int n);
    @(negedge clk);
    start = 1'b1;
    len   = (ADDRW + 1)'(n);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("first_rden", 32'(memRdEn), (n != 0) ? 32'd1 : 32'd0);
    if (n != 0) check("first_addr", 32'(memAddr), 32'd0);
  endtask

  task automatic finish(input int n);
    int cyc = 0;
    int budget = (n + 1) * (10 * BAUD + 3) + 40;
    int nwords = (n + 3) / 4;
    while (done_cnt == b_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(done_cnt > b_done), 32'd1);
    repeat (3) @(negedge clk);
    check("done_count", 32'(done_cnt - b_done), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    check("tx_idle", 32'(tx), 32'd1);
    check("frame_format", 32'(frame_err - b_err), 32'd0);
    check("rx_count", 32'(rx_q.size() - b_rx), 32'(n + 1));
    for (int i = 0; i < n; i++) check("data_byte", rx_at(b_rx + i), 32'(ref_byte(i)));
    check("checksum", rx_at(b_rx + n), 32'(ref_sum(n)));
    check("read_count", 32'(rd_q.size() - b_rd), 32'(nwords));
    for (int w = 0; w < nwords; w++) begin
      check("read_addr", (b_rd + w < rd_q.size()) ? 32'(rd_q[b_rd + w]) : 32'hxxxx_xxxx,
            32'((4 * w) % ASPAN));
    end
    for (int j = 1; j <= n; j++) begin
      check("gap", (b_gap + j < gap_q.size()) ? 32'(gap_q[b_gap + j]) : 32'hxxxx_xxxx,
            (j < n && (j % 4) == 0) ? 32'd3 : 32'd1);
    end
  endtask

  task automatic run_dump(input int n);
    snapshot();
    kick(n);
    finish(n);
  endtask

  task automatic fill_random();
    for (int i = 0; i < MEM_SIZE; i++) mem_b[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int n;
    rstB  = 1'b0;
    start = 1'b0;
    len   = '0;
    for (int i = 0; i < MEM_SIZE; i++) mem_b[i] = 8'h00;

    // Reset values while rstB is held low.
    #12;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rden", 32'(memRdEn), 32'd0);
    check("rst_addr", 32'(memAddr), 32'd0);
    #10;
    rstB = 1'b1;
    repeat (3) @(negedge clk);

    // Single word, four bytes.
    {mem_b[3], mem_b[2], mem_b[1], mem_b[0]} = 32'h4433_2211;
    run_dump(4);
    check("tp_chk_aa", rx_at(b_rx + 4), 32'h0000_00AA);

    // Empty dump: checksum frame only.
    run_dump(0);
    check("tp_chk_00", rx_at(b_rx), 32'h0000_0000);

    // Partial second word.
    {mem_b[3], mem_b[2], mem_b[1], mem_b[0]} = 32'h0403_0201;
    {mem_b[7], mem_b[6], mem_b[5], mem_b[4]} = 32'hFFFF_FF80;
    run_dump(5);
    check("tp_chk_8a", rx_at(b_rx + 5), 32'h0000_008A);

    // Checksum wraps modulo 256.
    mem_b[0] = 8'hFF;
    mem_b[1] = 8'h02;
    run_dump(2);
    check("tp_chk_01", rx_at(b_rx + 2), 32'h0000_0001);

    // start with a different len while busy is ignored.
    fill_random();
    snapshot();
    kick(4);
    repeat (20) @(negedge clk);
    start = 1'b1;
    len   = (ADDRW + 1)'(1);
    @(negedge clk);
    start = 1'b0;
    finish(4);
    repeat (10) @(negedge clk);
    check("no_second_busy", 32'(busy), 32'd0);
    check("no_second_read", 32'(rd_q.size() - b_rd), 32'd1);
    check("no_second_rx", 32'(rx_q.size() - b_rx), 32'd5);

    // Asynchronous reset in the middle of a data bit.
    fill_random();
    kick(3);
    repeat (10) @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'd1);
    #2;
    rstB = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rden", 32'(memRdEn), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_addr", 32'(memAddr), 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rstB = 1'b1;
    repeat (2) @(negedge clk);
    run_dump(1);

    // Randomized dumps, including lengths that straddle word boundaries.
    for (int t = 0; t < 8; t++) begin
      fill_random();
      n = $urandom_range(0, 20);
      run_dump(n);
    end
    fill_random();
    run_dump(MEM_SIZE - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
